// File: rtl/activity_pkg.sv
// Shared types, default widths and the saturating-add helper for the
// toggle activity monitor.
package activity_pkg;

    localparam int N_SIG_D    = 8;
    localparam int CNT_W_D    = 16;
    localparam int WIN_LEN_D  = 256;
    localparam int E_WEIGHT_D = 3;
    localparam int E_W_D      = 24;

    // Common working width for the saturating adder; callers size-cast in and out.
    localparam int SAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Returns {overflow, sum}; the sum is clamped to max_val when it would exceed it.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic [SAT_W-1:0] max_val
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return {1'b1, max_val};
        end
        return sum;
    endfunction

endpackage

// File: rtl/popcount_n.sv
// Combinational population count of an N-bit vector.
module popcount_n #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  i_bits,
    output logic [CW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Windowed switching-activity counter: sums bit transitions of sig over WIN_LEN
// cycles and reports toggle count and weighted energy through valid/ready.
module toggle_activity_monitor
    import activity_pkg::*;
#(
    parameter int N_SIG    = N_SIG_D,
    parameter int CNT_W    = CNT_W_D,
    parameter int WIN_LEN  = WIN_LEN_D,
    parameter int E_WEIGHT = E_WEIGHT_D,
    parameter int E_W      = E_W_D
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [N_SIG-1:0] sig,
    input  logic             start,
    input  logic             cont,
    input  logic             rd_ready,
    output logic             busy,
    output logic             rd_valid,
    output logic [CNT_W-1:0] toggles,
    output logic [E_W-1:0]   energy,
    output logic             ovf,
    output state_t           dbg_state
);

    // Handshake: a report transfers on a rising clk edge where rd_valid and
    // rd_ready are both high; rd_valid then drops and the report fields stay
    // stable for every cycle rd_valid is high.

    localparam int PC_W = $clog2(N_SIG + 1);
    localparam int WC_W = 16;
    localparam int P_W  = CNT_W + $clog2(E_WEIGHT + 1);
    localparam logic [SAT_W-1:0] CNT_MAX  = SAT_W'((64'd1 << CNT_W) - 64'd1);
    localparam logic [63:0]      E_MAX    = (64'd1 << E_W) - 64'd1;
    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_LEN - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [N_SIG-1:0]  r_prev;
    logic [CNT_W-1:0]  r_acc;
    logic [WC_W-1:0]   r_win_cnt;
    logic              r_acc_ovf;
    logic [CNT_W-1:0]  r_toggles;
    logic [E_W-1:0]    r_energy;
    logic              r_ovf;
    logic              r_busy;
    logic              r_rd_valid;

    logic [N_SIG-1:0]  w_diff;
    logic [PC_W-1:0]   w_pop;
    logic [SAT_W:0]    w_sat;
    logic [CNT_W-1:0]  w_acc_next;
    logic              w_add_ovf;
    logic [P_W-1:0]    w_prod;
    logic              w_e_clamp;
    logic [E_W-1:0]    w_energy;
    logic              w_last;
    logic              w_busy_d;
    logic              w_valid_d;

    assign w_diff = sig ^ r_prev;

    popcount_n #(
        .N  (N_SIG),
        .CW (PC_W)
    ) u_popcount (
        .i_bits  (w_diff),
        .o_count (w_pop)
    );

    assign w_sat      = sat_add(SAT_W'(r_acc), SAT_W'(w_pop), CNT_MAX);
    assign w_acc_next = CNT_W'(w_sat);
    assign w_add_ovf  = w_sat[SAT_W];

    // Energy is taken from the final count of the window, then clamped to E_W bits.
    assign w_prod    = P_W'(w_acc_next) * P_W'(E_WEIGHT);
    assign w_e_clamp = (64'(w_prod) > E_MAX);
    assign w_energy  = w_e_clamp ? E_W'(E_MAX) : E_W'(w_prod);

    assign w_last = (r_state == ST_SAMPLE) && (r_win_cnt == WIN_LAST);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_ARM;
            ST_ARM:    w_next_state = ST_SAMPLE;
            ST_SAMPLE: if (w_last) w_next_state = ST_REPORT;
            ST_REPORT: if (rd_ready) w_next_state = cont ? ST_ARM : ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_d  = (w_next_state != ST_IDLE);
        w_valid_d = (w_next_state == ST_REPORT);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_prev     <= '0;
            r_acc      <= '0;
            r_win_cnt  <= '0;
            r_acc_ovf  <= 1'b0;
            r_toggles  <= '0;
            r_energy   <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_busy     <= w_busy_d;
            r_rd_valid <= w_valid_d;
            case (r_state)
                ST_ARM: begin
                    r_prev    <= sig;
                    r_acc     <= '0;
                    r_win_cnt <= '0;
                    r_acc_ovf <= 1'b0;
                    r_ovf     <= 1'b0;
                end
                ST_SAMPLE: begin
                    r_prev    <= sig;
                    r_acc     <= w_acc_next;
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_acc_ovf <= r_acc_ovf | w_add_ovf;
                    if (w_last) begin
                        r_toggles <= w_acc_next;
                        r_energy  <= w_energy;
                        r_ovf     <= r_acc_ovf | w_add_ovf | w_e_clamp;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign rd_valid  = r_rd_valid;
    assign toggles   = r_toggles;
    assign energy    = r_energy;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Scoreboard bench: three monitor instances (default, CNT_W=8/WIN_LEN=64,
// WIN_LEN=1) driven one at a time against a window-sum reference model.
module tb_toggle_activity_monitor;
    import activity_pkg::*;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  sig_v   [3];
    logic        start_v [3];
    logic        cont_v  [3];
    logic        rdy_v   [3];
    logic        busy_v  [3];
    logic        rv_v    [3];
    logic        ovf_v   [3];
    logic [15:0] tog_v   [3];
    logic [23:0] en_v    [3];
    state_t      st_v    [3];

    logic [15:0] tog0, tog2;
    logic [7:0]  tog1;
    logic [23:0] en0, en1, en2;
    logic        busy0, busy1, busy2, rv0, rv1, rv2, ovf0, ovf1, ovf2;
    state_t      st0, st1, st2;

    assign tog_v[0] = tog0;  assign tog_v[1] = {8'd0, tog1};  assign tog_v[2] = tog2;
    assign en_v[0] = en0;    assign en_v[1] = en1;            assign en_v[2] = en2;
    assign busy_v[0] = busy0; assign busy_v[1] = busy1;       assign busy_v[2] = busy2;
    assign rv_v[0] = rv0;    assign rv_v[1] = rv1;            assign rv_v[2] = rv2;
    assign ovf_v[0] = ovf0;  assign ovf_v[1] = ovf1;          assign ovf_v[2] = ovf2;
    assign st_v[0] = st0;    assign st_v[1] = st1;            assign st_v[2] = st2;

    toggle_activity_monitor u_dut0 (
        .clk(clk), .reset_L(reset_L), .sig(sig_v[0]), .start(start_v[0]),
        .cont(cont_v[0]), .rd_ready(rdy_v[0]), .busy(busy0), .rd_valid(rv0),
        .toggles(tog0), .energy(en0), .ovf(ovf0), .dbg_state(st0)
    );

    toggle_activity_monitor #(.CNT_W(8), .WIN_LEN(64)) u_dut1 (
        .clk(clk), .reset_L(reset_L), .sig(sig_v[1]), .start(start_v[1]),
        .cont(cont_v[1]), .rd_ready(rdy_v[1]), .busy(busy1), .rd_valid(rv1),
        .toggles(tog1), .energy(en1), .ovf(ovf1), .dbg_state(st1)
    );

    toggle_activity_monitor #(.WIN_LEN(1)) u_dut2 (
        .clk(clk), .reset_L(reset_L), .sig(sig_v[2]), .start(start_v[2]),
        .cont(cont_v[2]), .rd_ready(rdy_v[2]), .busy(busy2), .rd_valid(rv2),
        .toggles(tog2), .energy(en2), .ovf(ovf2), .dbg_state(st2)
    );

    // Scoreboard entry: {ovf, energy[23:0], toggles[15:0]}
    logic [40:0] exp_q[$];
    logic [7:0]  vals [0:256];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int wl(input int k);
        return (k == 0) ? 256 : (k == 1) ? 64 : 1;
    endfunction

    function automatic int cw(input int k);
        return (k == 1) ? 8 : 16;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Builds the sig sequence of one window (vals[0] is captured by ARM,
    // vals[1..n] are the compare samples) and the report it must yield.
    task automatic fill(input int k, input int mode, input bit push);
        int n = wl(k);
        longint tot = 0;
        longint mx = (64'd1 << cw(k)) - 1;
        longint tg, en;
        bit ov;
        for (int i = 0; i <= n; i++) begin
            case (mode)
                1:       vals[i] = 8'hA5;
                2:       vals[i] = (i % 2 == 1) ? 8'h01 : 8'h00;
                3:       vals[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
                4:       vals[i] = (i == 0) ? 8'h00 : 8'h0F;
                default: vals[i] = 8'($urandom);
            endcase
        end
        for (int i = 1; i <= n; i++) begin
            tot += $countones(vals[i] ^ vals[i-1]);
        end
        ov = (tot > mx);
        tg = ov ? mx : tot;
        en = tg * 3;
        if (en > 64'hFF_FFFF) begin
            en = 64'hFF_FFFF;
            ov = 1'b1;
        end
        if (push) exp_q.push_back({ov, 24'(en), 16'(tg)});
    endtask

    // Called just after the edge that enters ARM.
    task automatic play(input int k);
        int n = wl(k);
        for (int i = 0; i <= n; i++) begin
            sig_v[k] = vals[i];
            if (i < n) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic latency_check(input int k);
        chk("valid_not_early", rv_v[k], 0);
        @(posedge clk); #1;
        chk("valid_rise", rv_v[k], 1);
        chk("busy_in_report", busy_v[k], 1);
    endtask

    task automatic start_window(input int k, input int mode);
        fill(k, mode, 1'b1);
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        chk("busy_in_arm", busy_v[k], 1);
        play(k);
        latency_check(k);
    endtask

    task automatic handshake(input int k, input int hold, input bit c, input int next_mode, input bit pulse);
        cont_v[k] = c;
        repeat (hold) begin
            sig_v[k] = 8'($urandom);
            start_v[k] = pulse ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        rdy_v[k] = 1'b1;
        sig_v[k] = 8'($urandom);
        start_v[k] = pulse;
        @(posedge clk); #1;
        rdy_v[k] = 1'b0;
        start_v[k] = 1'b0;
        chk("valid_drop", rv_v[k], 0);
        if (c) begin
            chk("cont_arm_busy", busy_v[k], 1);
            fill(k, next_mode, 1'b1);
            play(k);
            latency_check(k);
        end else begin
            chk("idle_busy", busy_v[k], 0);
            @(posedge clk); #1;
            chk("idle_stays", busy_v[k], 0);
        end
    endtask

    // Monitor: every cycle a report is presented it is compared with the head
    // of the queue; the head retires on the accepting edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_L) begin
                for (int k = 0; k < 3; k++) begin
                    if (rv_v[k]) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_report: dut %0d got toggles %0d, none expected", k, tog_v[k]);
                        end else begin
                            chk("report_toggles", tog_v[k], exp_q[0][15:0]);
                            chk("report_energy", en_v[k], exp_q[0][39:16]);
                            chk("report_ovf", ovf_v[k], exp_q[0][40]);
                            if (rdy_v[k]) void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            sig_v[k] = 8'h00; start_v[k] = 1'b0; cont_v[k] = 1'b0; rdy_v[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", busy_v[k], 0);
            chk("rst_valid", rv_v[k], 0);
            chk("rst_toggles", tog_v[k], 0);
            chk("rst_energy", en_v[k], 0);
            chk("rst_ovf", ovf_v[k], 0);
            chk("rst_state", st_v[k], ST_IDLE);
        end
        @(negedge clk) reset_L = 1'b1;
        @(posedge clk); #1;

        // Static bus, then square wave with backpressure, cont and stray starts.
        start_window(0, 1);
        handshake(0, 0, 1'b0, 0, 1'b0);
        start_window(0, 2);
        handshake(0, 20, 1'b1, 0, 1'b1);
        handshake(0, 3, 1'b1, 0, 1'b0);
        handshake(0, 2, 1'b0, 0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            start_window(0, 0);
            handshake(0, $urandom_range(0, 5), 1'b0, 0, 1'b0);
        end

        // Saturating instance.
        start_window(1, 3);
        handshake(1, 1, 1'b1, 0, 1'b0);
        handshake(1, 0, 1'b0, 0, 1'b0);

        // Single-cycle window.
        start_window(2, 4);
        handshake(2, 0, 1'b1, 0, 1'b0);
        handshake(2, 1, 1'b1, 0, 1'b0);
        handshake(2, 0, 1'b0, 0, 1'b0);

        // Reset ten compare cycles into a window, then a clean window.
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (11) begin
            sig_v[0] = 8'($urandom);
            @(posedge clk); #1;
        end
        reset_L = 1'b0;
        #1;
        chk("midrst_busy", busy_v[0], 0);
        chk("midrst_valid", rv_v[0], 0);
        chk("midrst_toggles", tog_v[0], 0);
        @(negedge clk) reset_L = 1'b1;
        @(posedge clk); #1;
        start_window(0, 0);
        handshake(0, 1, 1'b0, 0, 1'b0);

        repeat (4) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
